minesweeper_board: RTL and testbench

MINESWEEPER_BOARD -- requirements
Module: minesweeper_board

---
 rtl/minesweeper_board.sv | 139 +++++++++++++
 tb/tb_minesweeper_board.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/minesweeper_board.sv
// Minesweeper board generator: LFSR-driven mine placement that avoids the first-click cell,
// then a one-cell-per-cycle neighbour count pass. The board is readable once is_init is set.
module minesweeper_board #(
  parameter int X_SIZE      = 16,
  parameter int Y_SIZE      = 16,
  parameter int MINE_TARGET = 40
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic        btnC_Pulse,
  input  logic [3:0]  x_coord,
  input  logic [3:0]  y_coord,
  output logic [4:0]  cell_val,
  output logic [7:0]  num_mines,
  output logic [31:0] rand_o,
  output logic [31:0] seed,
  output logic        is_init
);

  localparam int unsigned CELLS     = 256;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, PLACE, COUNT, READY} state_e;

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] seed_q, seed_d;
  logic [7:0]  click_q, click_d;
  logic [7:0]  num_q, num_d;
  logic [3:0]  cx_q, cx_d;
  logic [3:0]  cy_q, cy_d;
  logic [4:0]  mem_q [CELLS];
  logic        place_we, count_we;
  logic [7:0]  cand, cnt_idx, rd_idx;
  logic [3:0]  nb_cnt;

  assign cand    = lfsr_q[7:0];
  assign cnt_idx = {cy_q, cx_q};
  assign rd_idx  = {y_coord, x_coord};

  // Mine count of the in-range neighbours of the cell being visited in COUNT
  always_comb begin
    int nx;
    int ny;
    nb_cnt = 4'd0;
    nx     = 0;
    ny     = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(cx_q) + dx;
        ny = int'(cy_q) + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < X_SIZE && ny >= 0 && ny < Y_SIZE)
          nb_cnt = nb_cnt + 4'(mem_q[{4'(ny), 4'(nx)}][4]);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    seed_d   = seed_q;
    click_d  = click_q;
    num_d    = num_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    place_we = 1'b0;
    count_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (btnC_Pulse) begin
          seed_d  = lfsr_q;
          click_d = rd_idx;
          state_d = PLACE;
        end
      end
      PLACE: begin
        if (num_q == 8'(MINE_TARGET)) begin
          state_d = COUNT;
          cx_d    = 4'd0;
          cy_d    = 4'd0;
        end else if (int'(cand[3:0]) < X_SIZE && int'(cand[7:4]) < Y_SIZE &&
                     !mem_q[cand][4] && cand != click_q) begin
          place_we = 1'b1;
          num_d    = num_q + 8'd1;
        end
      end
      COUNT: begin
        count_we = 1'b1;
        if (int'(cx_q) == X_SIZE - 1) begin
          cx_d = 4'd0;
          if (int'(cy_q) == Y_SIZE - 1) state_d = READY;
          else                          cy_d    = cy_q + 4'd1;
        end else begin
          cx_d = cx_q + 4'd1;
        end
      end
      READY:   state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= 32'h0000_0001;
      seed_q  <= 32'd0;
      click_q <= 8'd0;
      num_q   <= 8'd0;
      cx_q    <= 4'd0;
      cy_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      click_q <= click_d;
      num_q   <= num_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  // Cell array: mine bits written in PLACE, counts in COUNT
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(CELLS); i++) mem_q[i] <= 5'd0;
    end else begin
      if (place_we) mem_q[cand][4]       <= 1'b1;
      if (count_we) mem_q[cnt_idx][3:0]  <= nb_cnt;
    end
  end

  assign is_init   = (state_q == READY);
  assign num_mines = num_q;
  assign rand_o    = lfsr_q;
  assign seed      = seed_q;
  assign cell_val  = (is_init && int'(x_coord) < X_SIZE && int'(y_coord) < Y_SIZE) ?
                     mem_q[rd_idx] : 5'd0;

endmodule

// File: tb/tb_minesweeper_board.sv
// Directed bench for minesweeper_board with a cycle-level reference model of LFSR and placement.
module tb_minesweeper_board;

  logic        clk;
  logic        reset;
  logic        btn;
  logic [3:0]  x;
  logic [3:0]  y;
  logic [4:0]  cell_val;
  logic [7:0]  num_mines;
  logic [31:0] rand_w;
  logic [31:0] seed;
  logic        is_init;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0]  m_lfsr;
  logic [1:0]   m_state;
  logic [31:0]  m_seed;
  logic [7:0]   m_click;
  logic [7:0]   m_num;
  logic [8:0]   m_cnt;
  logic [255:0] m_mine;

  minesweeper_board dut (
    .board_clk (clk),
    .reset     (reset),
    .btnC_Pulse(btn),
    .x_coord   (x),
    .y_coord   (y),
    .cell_val  (cell_val),
    .num_mines (num_mines),
    .rand_o    (rand_w),
    .seed      (seed),
    .is_init   (is_init)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr  <= 32'h1;
      m_state <= 2'd0;
      m_seed  <= 32'd0;
      m_click <= 8'd0;
      m_num   <= 8'd0;
      m_cnt   <= 9'd0;
      m_mine  <= '0;
    end else begin
      m_lfsr <= lfsr_next(m_lfsr);
      case (m_state)
        2'd0: if (btn) begin
          m_seed  <= m_lfsr;
          m_click <= {y, x};
          m_state <= 2'd1;
        end
        2'd1: if (m_num == 8'd40) begin
          m_state <= 2'd2;
          m_cnt   <= 9'd0;
        end else if (!m_mine[m_lfsr[7:0]] && m_lfsr[7:0] != m_click) begin
          m_mine[m_lfsr[7:0]] <= 1'b1;
          m_num <= m_num + 8'd1;
        end
        2'd2: begin
          m_cnt <= m_cnt + 9'd1;
          if (m_cnt == 9'd255) m_state <= 2'd3;
        end
        default: ;
      endcase
    end
  end

  function automatic int nbc(input int cx, input int cy);
    int n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (!(dx == 0 && dy == 0) && cx + dx >= 0 && cx + dx < 16 && cy + dy >= 0 && cy + dy < 16)
          n += int'(m_mine[(cy + dy) * 16 + cx + dx]);
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic click(input logic [3:0] cx, input logic [3:0] cy);
    x   = cx;
    y   = cy;
    btn = 1'b1;
    tick(1);
    btn = 1'b0;
  endtask

  task automatic sweep_board(input string tag, input bit expect_zero);
    int mines = 0;
    logic [4:0] exp;
    for (int cy = 0; cy < 16; cy++) begin
      for (int cx = 0; cx < 16; cx++) begin
        x = 4'(cx);
        y = 4'(cy);
        #1;
        exp = expect_zero ? 5'd0 : {m_mine[cy * 16 + cx], 4'(nbc(cx, cy))};
        check_eq(tag, 32'(cell_val), 32'(exp));
        if (cell_val[4]) mines++;
      end
    end
    if (!expect_zero) check_eq({tag, "_mines"}, mines, 40);
  endtask

  task automatic wait_full(input string tag);
    int n = 0;
    while (num_mines != 8'd40 && n < 3000) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_num40"}, 32'(num_mines), 32'd40);
    n = 0;
    while (!is_init && n < 400) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_latency"}, n, 257);
  endtask

  logic [31:0] prev_rand, exp_seed, seed1;

  initial begin
    reset = 1'b1;
    btn   = 1'b0;
    x     = 4'd0;
    y     = 4'd0;
    #1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_eq("rand_in_reset", rand_w, 32'h1);
    end
    check_eq("init_reset", 32'(is_init), 32'd0);
    check_eq("num_reset", 32'(num_mines), 32'd0);
    check_eq("seed_reset", seed, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      prev_rand = rand_w;
      tick(1);
      check_eq("rand_model", rand_w, m_lfsr);
      check_eq("rand_changes", 32'(rand_w != prev_rand), 32'd1);
    end
    sweep_board("zero_idle", 1'b1);

    tick(1);
    exp_seed = m_lfsr;
    click(4'd3, 4'd5);
    check_eq("seed_capture", seed, exp_seed);
    check_eq("init_in_place", 32'(is_init), 32'd0);
    x = 4'd3;
    y = 4'd5;
    #1;
    check_eq("read_during_gen", 32'(cell_val), 32'd0);
    wait_full("gen1");
    check_eq("num_final", 32'(num_mines), 32'd40);
    check_eq("seed_hold", seed, exp_seed);
    check_eq("rand_after_gen", rand_w, m_lfsr);
    sweep_board("board1", 1'b0);
    x = 4'd3; y = 4'd5;   #1; check_eq("click_safe", 32'(cell_val[4]), 32'd0);
    x = 4'd0; y = 4'd0;   #1; check_eq("corner00", 32'(cell_val[3:0] <= 4'd3), 32'd1);
    x = 4'd15; y = 4'd15; #1; check_eq("corner1515", 32'(cell_val[3:0] <= 4'd3), 32'd1);
    x = 4'd0; y = 4'd7;   #1; check_eq("edge07", 32'(cell_val[3:0] <= 4'd5), 32'd1);

    tick(1);
    click(4'd7, 4'd7);
    tick(5);
    check_eq("seed_after_2nd", seed, exp_seed);
    check_eq("num_after_2nd", 32'(num_mines), 32'd40);
    check_eq("init_after_2nd", 32'(is_init), 32'd1);
    sweep_board("board1_again", 1'b0);
    seed1 = seed;

    // reset in the middle of the counting pass
    reset = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(3);
    click(4'd3, 4'd5);
    while (num_mines != 8'd40 && checks < 100000) tick(1);
    tick(100);
    x = 4'd3;
    y = 4'd5;
    reset = 1'b1;
    #1;
    check_eq("midcount_init", 32'(is_init), 32'd0);
    check_eq("midcount_num", 32'(num_mines), 32'd0);
    check_eq("midcount_cell", 32'(cell_val), 32'd0);
    check_eq("midcount_rand", rand_w, 32'h1);
    tick(3);
    reset = 1'b0;
    tick(7);
    check_eq("no_restart", 32'(num_mines), 32'd0);
    exp_seed = m_lfsr;
    click(4'd10, 4'd2);
    check_eq("seed2_capture", seed, exp_seed);
    check_eq("seed2_fresh", 32'(seed != seed1), 32'd1);
    wait_full("gen2");
    x = 4'd10; y = 4'd2; #1; check_eq("click2_safe", 32'(cell_val[4]), 32'd0);
    sweep_board("board2", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
